// File: rtl/audio_pdm_recorder_if.sv
// Control, microphone and BRAM write signals of the PDM recorder.
// monitor_sample/monitor_tick exist only when AUDIO_REC_MONITOR_EN is defined.
interface audio_pdm_recorder_if #(
    parameter int ADDR_W = 18
);
    logic              start;
    logic              stop;
    logic              pdm_data;
    logic              mic_clk;
    logic              mic_lrsel;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_din;
    logic              bram_we;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   rec_length;
`ifdef AUDIO_REC_MONITOR_EN
    logic [7:0]        monitor_sample;
    logic              monitor_tick;

    modport slave (
        input  start, stop, pdm_data,
        output mic_clk, mic_lrsel, bram_addr, bram_din, bram_we, busy, done, rec_length,
        output monitor_sample, monitor_tick
    );
    modport master (
        output start, stop, pdm_data,
        input  mic_clk, mic_lrsel, bram_addr, bram_din, bram_we, busy, done, rec_length,
        input  monitor_sample, monitor_tick
    );
`else
    modport slave (
        input  start, stop, pdm_data,
        output mic_clk, mic_lrsel, bram_addr, bram_din, bram_we, busy, done, rec_length
    );
    modport master (
        output start, stop, pdm_data,
        input  mic_clk, mic_lrsel, bram_addr, bram_din, bram_we, busy, done, rec_length
    );
`endif
endinterface

// File: rtl/audio_pdm_recorder.sv
// PDM microphone recorder: mic clock, decimation to 8-bit samples, sequential BRAM writes.
// Define AUDIO_REC_MONITOR_EN for the live monitor_sample/monitor_tick outputs.
//
// state | meaning
// IDLE  | after reset, waiting for start
// REC   | decimating the PDM stream and writing samples
// DONE  | take finished, rec_length holds its size
module audio_pdm_recorder #(
    parameter int CLK_HALF   = 25,
    parameter int DECIM      = 125,
    parameter int GAIN_SHIFT = 1,
    parameter int DEPTH      = 262144,
    parameter int ADDR_W     = 18
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    audio_pdm_recorder_if.slave  bus
);
    localparam int HALF_W = $clog2(CLK_HALF + 1);
    localparam int CNT_W  = $clog2(DECIM + 1);
    localparam int LEN_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, REC, DONE} state_t;

    state_t            state_q, state_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic              mic_clk_q, mic_clk_d;
    logic [1:0]        sync_q, sync_d;
    logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
    logic [CNT_W-1:0]  ones_q, ones_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  rec_len_q, rec_len_d;
    logic              we_q, we_d;
    logic [7:0]        din_q, din_d;
    logic              done_q, done_d;
    logic              half_tc, dec_run, bit_evt, win_done;
    logic [31:0]       scaled;
    logic [7:0]        sample;
`ifdef AUDIO_REC_MONITOR_EN
    logic [7:0]        mon_sample_q, mon_sample_d;
    logic              mon_tick_q, mon_tick_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            half_cnt_q   <= '0;
            mic_clk_q    <= 1'b0;
            sync_q       <= '0;
            evt_cnt_q    <= '0;
            ones_q       <= '0;
            wr_ptr_q     <= '0;
            rec_len_q    <= '0;
            we_q         <= 1'b0;
            din_q        <= '0;
            done_q       <= 1'b0;
`ifdef AUDIO_REC_MONITOR_EN
            mon_sample_q <= '0;
            mon_tick_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            mic_clk_q    <= mic_clk_d;
            sync_q       <= sync_d;
            evt_cnt_q    <= evt_cnt_d;
            ones_q       <= ones_d;
            wr_ptr_q     <= wr_ptr_d;
            rec_len_q    <= rec_len_d;
            we_q         <= we_d;
            din_q        <= din_d;
            done_q       <= done_d;
`ifdef AUDIO_REC_MONITOR_EN
            mon_sample_q <= mon_sample_d;
            mon_tick_q   <= mon_tick_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q + HALF_W'(1);
        mic_clk_d  = mic_clk_q;
        sync_d     = {sync_q[0], bus.pdm_data};
        evt_cnt_d  = evt_cnt_q;
        ones_d     = ones_q;
        wr_ptr_d   = wr_ptr_q;
        rec_len_d  = rec_len_q;
        we_d       = 1'b0;
        din_d      = din_q;
        done_d     = 1'b0;
`ifdef AUDIO_REC_MONITOR_EN
        mon_sample_d = mon_sample_q;
        mon_tick_d   = 1'b0;
        dec_run      = 1'b1;
`else
        dec_run      = (state_q == REC);
`endif
        half_tc = (half_cnt_q == HALF_W'(CLK_HALF - 1));
        if (half_tc) begin
            half_cnt_d = '0;
            mic_clk_d  = ~mic_clk_q;
        end

        // A window closes on the event after its DECIM-th bit; that event's bit opens the next one.
        bit_evt  = half_tc && mic_clk_q && dec_run;
        win_done = bit_evt && (evt_cnt_q == CNT_W'(DECIM));
        scaled   = 32'(ones_q) << GAIN_SHIFT;
        sample   = (scaled > 32'd255) ? 8'hFF : scaled[7:0];

        if (bit_evt) begin
            if (win_done) begin
                ones_d    = CNT_W'(sync_q[1]);
                evt_cnt_d = CNT_W'(1);
            end else begin
                ones_d    = ones_q + CNT_W'(sync_q[1]);
                evt_cnt_d = evt_cnt_q + CNT_W'(1);
            end
        end
        if (win_done && state_q == REC) begin
            we_d  = 1'b1;
            din_d = sample;
        end
`ifdef AUDIO_REC_MONITOR_EN
        if (win_done) begin
            mon_tick_d   = 1'b1;
            mon_sample_d = sample;
        end
`endif
        if (we_q) begin
            rec_len_d = rec_len_q + LEN_W'(1);
            if (wr_ptr_q != LAST_ADDR) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = REC;
                    wr_ptr_d  = '0;
                    rec_len_d = '0;
                    ones_d    = '0;
                    evt_cnt_d = '0;
                end
            end
            REC: begin
                if (bus.stop || (we_q && wr_ptr_q == LAST_ADDR)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mic_clk    = mic_clk_q;
    assign bus.mic_lrsel  = 1'b0;
    assign bus.bram_addr  = wr_ptr_q;
    assign bus.bram_din   = din_q;
    assign bus.bram_we    = we_q;
    assign bus.busy       = (state_q == REC);
    assign bus.done       = done_q;
    assign bus.rec_length = rec_len_q;
`ifdef AUDIO_REC_MONITOR_EN
    assign bus.monitor_sample = mon_sample_q;
    assign bus.monitor_tick   = mon_tick_q;
`endif
endmodule

// File: tb/tb_audio_pdm_recorder.sv
// Bench for audio_pdm_recorder: a bench-side microphone feeds bits on mic_clk falls, a window
// model predicts every BRAM write and done pulse, and a monitor compares whatever the DUTs present.
module tb_audio_pdm_recorder;
    localparam int CLK_HALF = 2;
    localparam int DECIM    = 8;
    localparam int GAIN     = 1;
    localparam int GAIN_HI  = 5;
    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 2;
    localparam int BIT_PER  = 2 * CLK_HALF;

    typedef struct {
        int addr;
        int din;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic pdm = 1'b0;

    always #5 clk = ~clk;

    audio_pdm_recorder_if #(.ADDR_W(ADDR_W)) bus ();
    audio_pdm_recorder_if #(.ADDR_W(ADDR_W)) bus_hi ();

    assign bus.start       = start;
    assign bus.stop        = stop;
    assign bus.pdm_data    = pdm;
    assign bus_hi.start    = start;
    assign bus_hi.stop     = stop;
    assign bus_hi.pdm_data = pdm;

    audio_pdm_recorder #(.CLK_HALF(CLK_HALF), .DECIM(DECIM), .GAIN_SHIFT(GAIN),
                         .DEPTH(DEPTH), .ADDR_W(ADDR_W))
        dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    audio_pdm_recorder #(.CLK_HALF(CLK_HALF), .DECIM(DECIM), .GAIN_SHIFT(GAIN_HI),
                         .DEPTH(DEPTH), .ADDR_W(ADDR_W))
        dut_hi (.clk_i(clk), .rst_i(rst), .bus(bus_hi));

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    wr_t exp_hi_q[$];
    int  done_exp_q[$];
    int  mode = 0;   // 0 random bits, 1 all ones, 2 alternating

    bit  m_rec = 1'b0;
    bit  m_wpend = 1'b0;
    bit  m_inrst = 1'b1;
    bit  m_complete_next = 1'b0;
    int  m_k = 0;
    int  m_len = 0;
    int  m_nwr = 0;
    bit  m_bits[$];
    bit  cur_bit = 1'b0;

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout_%s: condition never reached within the cycle budget (t=%0t)", name, $time);
    endtask

    // Reference model: one pass per clock edge, driven by what the edge sampled.
    initial begin : model
        bit s_start, s_stop, s_rst, evt, wp_next, end_now;
        int n, ones;
        forever begin
            @(posedge clk);
            s_start = start;
            s_stop  = stop;
            s_rst   = rst;
            #1;
            m_inrst = s_rst;
            evt     = 1'b0;
            if (s_rst) begin
                m_k = 0; m_rec = 0; m_wpend = 0; m_len = 0; m_nwr = 0;
                m_bits.delete();
            end else begin
                m_k++;
                evt     = (m_k % BIT_PER) == 0;
                wp_next = 1'b0;
                end_now = 1'b0;
                if (m_rec) begin
                    if (evt) begin
                        n = m_bits.size();
                        if (n >= DECIM && n % DECIM == 0) begin
                            ones = 0;
                            for (int i = n - DECIM; i < n; i++) ones += int'(m_bits[i]);
                            exp_q.push_back('{m_nwr, sat8(ones << GAIN)});
                            exp_hi_q.push_back('{m_nwr, sat8(ones << GAIN_HI)});
                            m_nwr++;
                            wp_next = 1'b1;
                        end
                        m_bits.push_back(cur_bit);
                    end
                    if (m_wpend) begin
                        m_len++;
                        if (m_len == DEPTH) end_now = 1'b1;
                    end
                    if (s_stop) end_now = 1'b1;
                    m_wpend = wp_next;
                    if (end_now) begin
                        m_rec = 1'b0;
                        done_exp_q.push_back(m_len);
                    end
                end else if (s_start) begin
                    m_rec = 1'b1; m_len = 0; m_nwr = 0; m_wpend = 1'b0;
                    m_bits.delete();
                end
            end
            // The microphone presents a new bit right after each mic_clk fall.
            if (s_rst || evt) begin
                case (mode)
                    1:       cur_bit = 1'b1;
                    2:       cur_bit = ~cur_bit;
                    default: cur_bit = 1'($urandom_range(0, 1));
                endcase
                pdm = cur_bit;
            end
            m_complete_next = m_rec && ((m_k + 1) % BIT_PER == 0) &&
                              m_bits.size() >= DECIM && (m_bits.size() % DECIM == 0);
        end
    end

    initial begin : monitor
        wr_t w;
        int  d;
        forever begin
            @(negedge clk);
            if (bus.bram_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %0d din %0d, required no write (t=%0t)",
                             bus.bram_addr, bus.bram_din, $time);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", int'(bus.bram_addr), w.addr);
                    check("wr_din", int'(bus.bram_din), w.din);
                end
            end
            if (bus_hi.bram_we === 1'b1) begin
                if (exp_hi_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write_hi: got addr %0d din %0d, required no write (t=%0t)",
                             bus_hi.bram_addr, bus_hi.bram_din, $time);
                end else begin
                    w = exp_hi_q.pop_front();
                    check("wr_addr_hi", int'(bus_hi.bram_addr), w.addr);
                    check("wr_din_hi", int'(bus_hi.bram_din), w.din);
                end
            end
            if (bus.done === 1'b1) begin
                if (done_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1, required 0 (t=%0t)", $time);
                end else begin
                    d = done_exp_q.pop_front();
                    check("rec_length", int'(bus.rec_length), d);
                    check("busy_at_done", int'(bus.busy), 0);
                end
            end
            if (!m_inrst) begin
                check("busy", int'(bus.busy), int'(m_rec));
                check("mic_clk", int'(bus.mic_clk), (m_k / CLK_HALF) % 2);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit s, input bit p);
        @(negedge clk);
        start = s;
        stop  = p;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_take_end(input string name, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!m_rec && exp_q.size() == 0 && exp_hi_q.size() == 0 && done_exp_q.size() == 0) break;
        end
        if (i == limit) timeout(name);
    endtask

    task automatic wait_len(input int n, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (m_len >= n) break;
        end
        if (i == limit) timeout("rec_length_reach");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, int'(bus.bram_we), 0);
        check({tag, "_addr"}, int'(bus.bram_addr), 0);
        check({tag, "_din"}, int'(bus.bram_din), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_len"}, int'(bus.rec_length), 0);
        check({tag, "_mic_clk"}, int'(bus.mic_clk), 0);
        check({tag, "_lrsel"}, int'(bus.mic_lrsel), 0);
        check({tag, "_we_hi"}, int'(bus_hi.bram_we), 0);
    endtask

    initial begin : stim
        int i;
        rst = 1'b1;
        cycles(3);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Constant ones: four writes of 16 (255 on the high-gain copy), then done at rec_length 4.
        mode = 1;
        cycles(12);
        pulse(1'b1, 1'b0);
        wait_take_end("all_ones", 400);

        // Alternating bits: four ones per window.
        mode = 2;
        cycles(8);
        pulse(1'b1, 1'b0);
        wait_take_end("alternating", 400);

        // Stop half a window after the first write: partial window dropped.
        mode = 0;
        pulse(1'b1, 1'b0);
        wait_len(1, 200);
        cycles(4 * BIT_PER);
        pulse(1'b0, 1'b1);
        wait_take_end("early_stop", 100);

        // Reset on the cycle before the third write would appear.
        pulse(1'b1, 1'b0);
        wait_len(2, 300);
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_complete_next) break;
        end
        if (i == 100) timeout("pre_write_cycle");
        rst = 1'b1;
        cycles(2);
        check_reset_outputs("midrec");
        rst = 1'b0;
        cycles(5);

        // Stop in IDLE is ignored; start with stop together starts; start during REC is ignored.
        pulse(1'b0, 1'b1);
        cycles(6);
        pulse(1'b1, 1'b1);
        wait_len(1, 200);
        pulse(1'b1, 1'b0);
        wait_take_end("start_in_rec", 400);

        // Restart from DONE; stop lands in the write cycle of the second sample, which still counts.
        pulse(1'b1, 1'b0);
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_wpend && m_nwr == 2) break;
        end
        if (i == 300) timeout("second_write_cycle");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_take_end("stop_on_write", 200);

        // One more full random take.
        pulse(1'b1, 1'b0);
        wait_take_end("random_full", 400);

        cycles(10);
        check("leftover_writes", exp_q.size(), 0);
        check("leftover_writes_hi", exp_hi_q.size(), 0);
        check("leftover_done", done_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
